// File: rtl/register_file_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | register_file_writer: storage and write port of the register file, with  |
// | single/burst writes and a one-entry-per-cycle clear sweep.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module register_file_writer #(
    parameter int NUM_REGS = 64,
    parameter int DATA_W   = 16,
    parameter int IDX_W    = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_valid_i,
    output logic                       wr_ready_o,
    input  logic                       wr_burst_i,
    input  logic [IDX_W-1:0]           wr_index_i,
    input  logic [DATA_W-1:0]          wr_data_i,
    input  logic                       ptr_load_i,
    input  logic [IDX_W-1:0]           ptr_value_i,
    input  logic                       clr_req_i,
    output logic [NUM_REGS*DATA_W-1:0] regs_o,
    output logic [IDX_W-1:0]           wr_ptr_o,
    output logic                       busy_o,
    output logic                       clr_done_o
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] C_LAST = IDX_W'(NUM_REGS - 1);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic                busy_q, busy_d;
    logic                clr_done_q, clr_done_d;
    logic [DATA_W-1:0]   mem_q [NUM_REGS];

    logic                w_fire;
    logic [IDX_W-1:0]    w_target;

    assign wr_ready_o = (state_q == IDLE) & ~clr_req_i;
    assign w_fire     = wr_valid_i & wr_ready_o;
    assign w_target   = wr_burst_i ? ptr_q : wr_index_i;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clr_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_req_i) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + IDX_W'(1);
                if (cnt_q == C_LAST) begin
                    state_d    = IDLE;
                    clr_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == CLEAR);
    end

    // Load has priority; a same-cycle burst write already used the old pointer.
    always_comb begin
        ptr_d = ptr_q;
        if (ptr_load_i) begin
            ptr_d = ptr_value_i;
        end else if (w_fire && wr_burst_i) begin
            ptr_d = ptr_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ptr_q      <= '0;
            busy_q     <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            busy_q     <= busy_d;
            clr_done_q <= clr_done_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (state_q == CLEAR) begin
            mem_q[cnt_q] <= '0;
        end else if (w_fire) begin
            mem_q[w_target] <= wr_data_i;
        end
    end

    generate
        for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
            assign regs_o[DATA_W*g +: DATA_W] = mem_q[g];
        end
    endgenerate

    assign wr_ptr_o   = ptr_q;
    assign busy_o     = busy_q;
    assign clr_done_o = clr_done_q;

endmodule
`default_nettype wire

// File: tb/tb_register_file_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_register_file_writer: directed vector table plus clear/reset sequences |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_register_file_writer;

    localparam int NR = 64;
    localparam int DW = 16;
    localparam int IW = 6;

    logic             clk;
    logic             rst_n;
    logic             wr_valid;
    logic             wr_ready;
    logic             wr_burst;
    logic [IW-1:0]    wr_index;
    logic [DW-1:0]    wr_data;
    logic             ptr_load;
    logic [IW-1:0]    ptr_value;
    logic             clr_req;
    logic [NR*DW-1:0] regs;
    logic [IW-1:0]    wr_ptr;
    logic             busy;
    logic             clr_done;

    logic [NR*DW-1:0] exp_regs;
    int               n_vec;
    int               n_err;

    register_file_writer #(.NUM_REGS(NR), .DATA_W(DW), .IDX_W(IW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_valid_i  (wr_valid),
        .wr_ready_o  (wr_ready),
        .wr_burst_i  (wr_burst),
        .wr_index_i  (wr_index),
        .wr_data_i   (wr_data),
        .ptr_load_i  (ptr_load),
        .ptr_value_i (ptr_value),
        .clr_req_i   (clr_req),
        .regs_o      (regs),
        .wr_ptr_o    (wr_ptr),
        .busy_o      (busy),
        .clr_done_o  (clr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          valid;
        logic          burst;
        logic [IW-1:0] idx;
        logic [DW-1:0] data;
        logic          pl;
        logic [IW-1:0] pv;
        logic [IW-1:0] chk_idx;
        logic [DW-1:0] exp_entry;
        logic [IW-1:0] exp_ptr;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_regs(input string name);
        int bad;
        bad = -1;
        n_vec++;
        for (int i = NR - 1; i >= 0; i--) begin
            if (regs[DW*i +: DW] !== exp_regs[DW*i +: DW]) bad = i;
        end
        if (bad >= 0) begin
            n_err++;
            $display("FAIL %s: entry %0d got %0h expected %0h", name, bad,
                     regs[DW*bad +: DW], exp_regs[DW*bad +: DW]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_valid  = 1'b0;
        wr_burst  = 1'b0;
        wr_index  = '0;
        wr_data   = '0;
        ptr_load  = 1'b0;
        ptr_value = '0;
        clr_req   = 1'b0;
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;
        int done_k;
        int ready_bad;
        int activity;

        n_vec    = 0;
        n_err    = 0;
        exp_regs = '0;

        //             valid burst idx     data        pl    pv      chk     entry       ptr
        vecs[0]  = '{1'b1, 1'b0, 6'd5,  16'hBEEF, 1'b0, 6'd0,  6'd5,  16'hBEEF, 6'd0 };
        vecs[1]  = '{1'b0, 1'b0, 6'd0,  16'h0000, 1'b1, 6'd62, 6'd62, 16'h0000, 6'd62};
        vecs[2]  = '{1'b1, 1'b1, 6'd7,  16'h00A1, 1'b0, 6'd0,  6'd62, 16'h00A1, 6'd63};
        vecs[3]  = '{1'b1, 1'b1, 6'd7,  16'h00A2, 1'b0, 6'd0,  6'd63, 16'h00A2, 6'd0 };
        vecs[4]  = '{1'b1, 1'b1, 6'd7,  16'h00A3, 1'b0, 6'd0,  6'd0,  16'h00A3, 6'd1 };
        vecs[5]  = '{1'b1, 1'b0, 6'd10, 16'h1234, 1'b0, 6'd0,  6'd10, 16'h1234, 6'd1 };
        vecs[6]  = '{1'b1, 1'b1, 6'd20, 16'h5555, 1'b1, 6'd40, 6'd1,  16'h5555, 6'd40};
        vecs[7]  = '{1'b1, 1'b0, 6'd10, 16'h4321, 1'b0, 6'd0,  6'd10, 16'h4321, 6'd40};
        vecs[8]  = '{1'b0, 1'b0, 6'd11, 16'hFFFF, 1'b0, 6'd0,  6'd11, 16'h0000, 6'd40};
        vecs[9]  = '{1'b1, 1'b1, 6'd0,  16'h0F0F, 1'b0, 6'd0,  6'd40, 16'h0F0F, 6'd41};
        vecs[10] = '{1'b0, 1'b1, 6'd0,  16'h0000, 1'b1, 6'd63, 6'd63, 16'h00A2, 6'd63};
        vecs[11] = '{1'b1, 1'b1, 6'd0,  16'h7777, 1'b0, 6'd0,  6'd63, 16'h7777, 6'd0 };

        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_regs("reset_regs");
        chk("reset_ptr",      32'(wr_ptr),   32'd0);
        chk("reset_busy",     32'(busy),     32'd0);
        chk("reset_ready",    32'(wr_ready), 32'd1);
        chk("reset_clr_done", 32'(clr_done), 32'd0);

        tick();
        for (int v = 0; v < 12; v++) begin
            wr_valid  = vecs[v].valid;
            wr_burst  = vecs[v].burst;
            wr_index  = vecs[v].idx;
            wr_data   = vecs[v].data;
            ptr_load  = vecs[v].pl;
            ptr_value = vecs[v].pv;
            #1;
            chk($sformatf("vec%0d_ready", v), 32'(wr_ready), 32'd1);
            tick();
            idle_inputs();
            exp_regs[DW*vecs[v].chk_idx +: DW] = vecs[v].exp_entry;
            chk_regs($sformatf("vec%0d_regs", v));
            chk($sformatf("vec%0d_ptr", v), 32'(wr_ptr), 32'(vecs[v].exp_ptr));
        end

        // Fill every entry through bursts starting from pointer 0.
        for (int i = 0; i < NR; i++) begin
            wr_valid = 1'b1;
            wr_burst = 1'b1;
            wr_data  = 16'(i * 3 + 1);
            exp_regs[DW*i +: DW] = 16'(i * 3 + 1);
            tick();
        end
        idle_inputs();
        chk_regs("fill_regs");

        clr_req = 1'b1;
        #1;
        chk("clr_ready_low", 32'(wr_ready), 32'd0);
        tick();
        clr_req   = 1'b0;
        busy_cnt  = 0;
        done_cnt  = 0;
        done_k    = -1;
        ready_bad = 0;
        for (int k = 0; k < 70; k++) begin
            if (busy) busy_cnt++;
            if (busy && wr_ready) ready_bad++;
            if (clr_done) begin
                done_cnt++;
                done_k = k;
            end
            ptr_load  = (k == 10);
            ptr_value = 6'd9;
            clr_req   = (k == 30);
            tick();
        end
        idle_inputs();
        exp_regs = '0;
        chk("sweep_busy_cycles", 32'(busy_cnt),  32'd64);
        chk("sweep_done_pulses", 32'(done_cnt),  32'd1);
        chk("sweep_done_cycle",  32'(done_k),    32'd64);
        chk("sweep_ready_busy",  32'(ready_bad), 32'd0);
        chk("sweep_ptr_load",    32'(wr_ptr),    32'd9);
        chk_regs("sweep_regs");

        // Clear request beats a simultaneous write; the retry lands afterwards.
        wr_valid = 1'b1;
        wr_index = 6'd3;
        wr_data  = 16'hABCD;
        clr_req  = 1'b1;
        #1;
        chk("race_ready", 32'(wr_ready), 32'd0);
        tick();
        idle_inputs();
        for (int k = 0; k < 80 && !clr_done; k++) tick();
        chk("race_done_seen", 32'(clr_done), 32'd1);
        chk_regs("race_no_write");
        wr_valid = 1'b1;
        wr_index = 6'd3;
        wr_data  = 16'hABCD;
        tick();
        idle_inputs();
        exp_regs[DW*3 +: DW] = 16'hABCD;
        chk_regs("race_retry");

        // Reset in the middle of a sweep.
        wr_valid = 1'b1;
        wr_index = 6'd60;
        wr_data  = 16'h1111;
        tick();
        idle_inputs();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (19) tick();
        chk("midrst_busy_before", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_regs = '0;
        chk_regs("midrst_regs");
        chk("midrst_ptr",      32'(wr_ptr),   32'd0);
        chk("midrst_busy",     32'(busy),     32'd0);
        chk("midrst_clr_done", 32'(clr_done), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        activity = 0;
        for (int k = 0; k < 70; k++) begin
            tick();
            if (busy || clr_done) activity++;
        end
        chk("midrst_no_resume", 32'(activity), 32'd0);
        chk("midrst_ready",     32'(wr_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
